// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: count controls in, count and flags out.
// master = controller side, slave = counter side.
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             ovf_clear;
    logic [WIDTH-1:0] counter_out;
    logic             tc;
    logic             ovf_sticky;

    modport master (
        output enable, up_down, load, load_value, ovf_clear,
        input  counter_out, tc, ovf_sticky
    );

    modport slave (
        input  enable, up_down, load, load_value, ovf_clear,
        output counter_out, tc, ovf_sticky
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable modulus, load, wrap/saturate, tc pulse and sticky overflow.
// Optional prescaler compiled in with `define COUNTER_PRESCALE_EN.
module updown_mod_counter #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     SATURATE  = 0,
    parameter int unsigned     PRESC_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    updown_mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    // Elaboration-time parameter range checks
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("updown_mod_counter: WIDTH out of range 2..32");
        end
        if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("updown_mod_counter: MAX_VAL out of range 1..2**WIDTH-1");
        end
        if (PRESC_DIV < 2 || PRESC_DIV > 256) begin : g_bad_presc
            $error("updown_mod_counter: PRESC_DIV out of range 2..256");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_zero;
    logic             boundary;
    logic             step;

    assign load_clamped = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
    assign at_max       = (count_q == MAX_V);
    assign at_zero      = (count_q == '0);
    assign boundary     = bus.up_down ? at_max : at_zero;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               presc_tick;

    assign presc_tick = (presc_q == PRESC_W'(PRESC_DIV - 1));
    assign step       = bus.enable & ~bus.load & presc_tick;

    // Prescaler: counts enabled cycles, holds when disabled, cleared by load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (bus.load) begin
            presc_d = '0;
        end else if (bus.enable) begin
            presc_d = presc_tick ? '0 : presc_q + PRESC_W'(1);
        end
    end
`else
    assign step = bus.enable & ~bus.load;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next count: load beats step; increments only happen below MAX_V so never overflow WIDTH
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (bus.load) begin
            count_d = load_clamped;
        end else if (step) begin
            tc_d = boundary;
            if (bus.up_down) begin
                if (at_max) begin
                    count_d = (SATURATE != 0) ? MAX_V : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    count_d = (SATURATE != 0) ? '0 : MAX_V;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        if (bus.ovf_clear) begin
            ovf_d = 1'b0;
        end
        // A boundary event on the same edge as a clear keeps the flag set
        if (step && boundary) begin
            ovf_d = 1'b1;
        end
    end

    assign bus.counter_out = count_q;
    assign bus.tc          = tc_q;
    assign bus.ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: wrap (MAX 9), saturate (MAX 9) and 4-bit full-range instances
// share one stimulus; expectations are hand-computed per instance.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [7:0] load_value;
    logic       ovf_clear;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(8)) if_w ();
    updown_mod_counter_if #(.WIDTH(8)) if_s ();
    updown_mod_counter_if #(.WIDTH(4)) if_f ();

    assign if_w.enable = enable;  assign if_w.up_down = up_down;  assign if_w.load = load;
    assign if_w.load_value = load_value;  assign if_w.ovf_clear = ovf_clear;
    assign if_s.enable = enable;  assign if_s.up_down = up_down;  assign if_s.load = load;
    assign if_s.load_value = load_value;  assign if_s.ovf_clear = ovf_clear;
    assign if_f.enable = enable;  assign if_f.up_down = up_down;  assign if_f.load = load;
    assign if_f.load_value = load_value[3:0];  assign if_f.ovf_clear = ovf_clear;

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(64'd9), .SATURATE(0), .PRESC_DIV(3)) u_w (
        .clk(clk), .reset(reset), .bus(if_w.slave));
    updown_mod_counter #(.WIDTH(8), .MAX_VAL(64'd9), .SATURATE(1), .PRESC_DIV(3)) u_s (
        .clk(clk), .reset(reset), .bus(if_s.slave));
    updown_mod_counter #(.WIDTH(4), .SATURATE(0), .PRESC_DIV(3)) u_f (
        .clk(clk), .reset(reset), .bus(if_f.slave));

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic [7:0] c, input logic t, input logic o,
                             input int ec, input int et, input int eo);
        check({tag, ".count"}, 32'(c), 32'(ec));
        check({tag, ".tc"},    32'(t), 32'(et));
        check({tag, ".ovf"},   32'(o), 32'(eo));
    endtask

    // Apply inputs away from the edge, clock once, sample just after the edge
    task automatic drive(input int ld, input int lv, input int en, input int ud, input int oc);
        @(negedge clk);
        load = 1'(ld); load_value = 8'(lv); enable = 1'(en); up_down = 1'(ud); ovf_clear = 1'(oc);
        @(posedge clk);
        #1;
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic run_prescale();
        logic        en_pat [14] = '{1,1,1,1,1,1,1,1,1, 1, 0,0, 1,1};
        int unsigned exp_cnt[14] = '{0,0,1,1,1,2,2,2,3, 3, 3,3, 3,4};
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, int'(en_pat[i]), 1, 0);
            check($sformatf("presc[%0d].count", i), 32'(if_w.counter_out), exp_cnt[i]);
            check($sformatf("presc[%0d].tc", i), 32'(if_w.tc), 0);
        end
    endtask
`else
    typedef struct {
        int ld, lv, en, ud, oc;
        int wc, wt, wo;
        int sc, st, so;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int ld, input int lv, input int en, input int ud, input int oc,
                       input int wc, input int wt, input int wo,
                       input int sc, input int st, input int so);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.ud = ud; v.oc = oc;
        v.wc = wc; v.wt = wt; v.wo = wo; v.sc = sc; v.st = st; v.so = so;
        vecs.push_back(v);
    endtask

    task automatic run_default();
        // ld lv en ud oc | wrap cnt tc ovf | sat cnt tc ovf
        for (int i = 1; i <= 9; i++) add(0, 0, 1, 1, 0, i, 0, 0, i, 0, 0);
        add(0,  0, 1, 1, 0,  0, 1, 1,  9, 1, 1);   // up boundary
        add(0,  0, 0, 1, 0,  0, 0, 1,  9, 0, 1);   // disabled: hold, tc drops
        add(0,  0, 0, 1, 1,  0, 0, 0,  9, 0, 0);   // clear while disabled
        add(1,  2, 1, 0, 0,  2, 0, 0,  2, 0, 0);   // load 2
        add(0,  0, 1, 0, 0,  1, 0, 0,  1, 0, 0);
        add(0,  0, 1, 0, 0,  0, 0, 0,  0, 0, 0);
        add(0,  0, 1, 0, 0,  9, 1, 1,  0, 1, 1);   // down boundary
        add(0,  0, 1, 0, 0,  8, 0, 1,  0, 1, 1);   // saturate holds 0 with tc again
        add(0,  0, 0, 0, 1,  8, 0, 0,  0, 0, 0);
        add(1, 13, 1, 1, 0,  9, 0, 0,  9, 0, 0);   // clamp, load beats step
        add(0,  0, 1, 1, 0,  0, 1, 1,  9, 1, 1);
        add(0,  0, 0, 1, 1,  0, 0, 0,  9, 0, 0);
        add(1,  9, 0, 1, 0,  9, 0, 0,  9, 0, 0);
        add(0,  0, 1, 1, 1,  0, 1, 1,  9, 1, 1);   // set beats clear
        add(0,  0, 1, 0, 0,  9, 1, 1,  8, 0, 1);   // direction change
        add(0,  0, 1, 1, 0,  0, 1, 1,  9, 0, 1);
        add(1,  5, 0, 1, 0,  5, 0, 1,  5, 0, 1);   // load while disabled
        add(1,  0, 1, 0, 1,  0, 0, 0,  0, 0, 0);   // load + clear, no boundary step
        add(0,  0, 0, 1, 0,  0, 0, 0,  0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud, vecs[i].oc);
            check_dut($sformatf("vec%0d.wrap", i), if_w.counter_out, if_w.tc, if_w.ovf_sticky,
                      vecs[i].wc, vecs[i].wt, vecs[i].wo);
            check_dut($sformatf("vec%0d.sat", i), if_s.counter_out, if_s.tc, if_s.ovf_sticky,
                      vecs[i].sc, vecs[i].st, vecs[i].so);
        end

        // Asynchronous reset mid-count on the 4-bit instance
        drive(1, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0);
        check_dut("w4.pre_reset", 8'(if_f.counter_out), if_f.tc, if_f.ovf_sticky, 5, 0, 0);
        #2 reset = 1'b1;
        #1;
        check_dut("w4.async_reset", 8'(if_f.counter_out), if_f.tc, if_f.ovf_sticky, 0, 0, 0);
        @(negedge clk);
        enable = 1'b0; load = 1'b0; ovf_clear = 1'b0;
        reset = 1'b0;
        drive(0, 0, 1, 1, 0);
        check_dut("w4.first_step", 8'(if_f.counter_out), if_f.tc, if_f.ovf_sticky, 1, 0, 0);

        // Asynchronous reset while tc and ovf are high
        drive(1, 9, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        check_dut("wrap.pre_reset", if_w.counter_out, if_w.tc, if_w.ovf_sticky, 0, 1, 1);
        #2 reset = 1'b1;
        #1;
        check_dut("wrap.async_reset", if_w.counter_out, if_w.tc, if_w.ovf_sticky, 0, 0, 0);
        check_dut("sat.async_reset", if_s.counter_out, if_s.tc, if_s.ovf_sticky, 0, 0, 0);
        @(negedge clk);
        enable = 1'b0;
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = '0; ovf_clear = 1'b0;
        @(posedge clk);
        #1;
        check_dut("reset.wrap", if_w.counter_out, if_w.tc, if_w.ovf_sticky, 0, 0, 0);
        check_dut("reset.sat", if_s.counter_out, if_s.tc, if_s.ovf_sticky, 0, 0, 0);
        check_dut("reset.w4", 8'(if_f.counter_out), if_f.tc, if_f.ovf_sticky, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
`ifdef COUNTER_PRESCALE_EN
        run_prescale();
`else
        run_default();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down counter with programmable modulus, synchronous load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Next-generation replacement for the fixed 4-bit up-counter used in timer, event-count and address-sequencing paths. One clock domain; asynchronous active-high reset.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (2..32)
- MAX_VAL, 2**WIDTH-1, top of count range; legal range is 1..2**WIDTH-1
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries
- PRESC_DIV, 4, prescale divisor (2..256); used only when COUNTER_PRESCALE_EN is defined

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  count enable, sampled on clk
- up_down  input  1  1 = count up, 0 = count down
- load  input  1  synchronous load strobe
- load_value  input  WIDTH  value to load
- ovf_clear  input  1  synchronous clear of ovf_sticky
- counter_out  output  WIDTH  current count (registered)
- tc  output  1  one-cycle terminal-count pulse (registered)
- ovf_sticky  output  1  set on any boundary event, held until cleared

## Operation
- Reset values: counter_out = 0, tc = 0, ovf_sticky = 0, prescaler count = 0.
- Per-edge priority: reset > load > count step > hold.
- Load: counter_out <= min(load_value, MAX_VAL); tc = 0 that cycle; prescaler count cleared; ovf_sticky unaffected except by ovf_clear.
- Count step occurs when enable = 1 and load = 0 (and the prescaler tick is set, when compiled in).
- Up step: counter_out < MAX_VAL -> +1. At MAX_VAL: wrap mode -> 0; saturate mode -> stays MAX_VAL.
- Down step: counter_out > 0 -> -1. At 0: wrap mode -> MAX_VAL; saturate mode -> stays 0.
- Boundary event: a step taken from MAX_VAL going up, or from 0 going down. It applies in both modes.
- On a boundary event, tc = 1 for exactly the cycle in which the new counter_out is visible. tc = 0 otherwise.
- ovf_sticky is set on a boundary event and cleared by ovf_clear. If both occur on the same edge, set wins.
- Arithmetic is modulo MAX_VAL+1 in wrap mode. No intermediate value may exceed WIDTH bits. A MAX_VAL of 2**WIDTH-1 must not need an extra bit.
- Changing up_down mid-count takes effect on the next step. There is no state machine beyond the prescaler.
- enable = 0 freezes all state except load and ovf_clear.

## Timing
- All outputs are registered. Latency from a sampled input to the output change is 1 clk edge.
- Reset asserts counter_out, tc and ovf_sticky immediately (asynchronously). Deassertion is synchronous to the design. The first step is possible on the first edge after reset falls.
- A reset asserted mid-count or mid-prescale discards all state, including the partial prescale count.
- No #delays in RTL. No combinational path from inputs to outputs.

## Configuration
- COUNTER_PRESCALE_EN defined:
  - An internal prescaler counts enabled cycles from 0 to PRESC_DIV-1.
  - A count step occurs only on the enabled cycle where the prescaler is at PRESC_DIV-1; the prescaler then returns to 0.
  - The prescaler holds while enable = 0 and is cleared by load and by reset.
- COUNTER_PRESCALE_EN undefined:
  - No prescaler logic exists and PRESC_DIV is ignored.
  - Every enabled, non-load cycle is a count step.

## Test plan
- Reset mid-count: WIDTH=4, default MAX_VAL, wrap. Count up 5 steps, then assert reset asynchronously between edges -> counter_out = 0, tc = 0, ovf_sticky = 0 immediately; after release, 1 step -> 1.
- Up wrap: MAX_VAL=9, wrap, up, enable held high for 10 cycles from 0 -> sequence 1..9,0; tc high only with 0; ovf_sticky = 1 afterwards.
- Down saturate: MAX_VAL=9, SATURATE=1, load 2, then down for 4 cycles -> 1,0,0,0; tc high on both held-0 cycles; ovf_clear then clears ovf_sticky to 0.
- Load clamp and priority: MAX_VAL=9, load_value=13 with load=1 and enable=1 -> counter_out = 9, tc = 0. Next cycle up step -> 0 with tc = 1.
- Set/clear collision: at counter_out = MAX_VAL with ovf_sticky = 0, assert up step and ovf_clear together -> ovf_sticky = 1.
- Prescale (macro defined): PRESC_DIV=3, enable high for 9 cycles from 0 -> counter_out = 1, 2, 3 after cycles 3, 6, 9. Drop enable for 2 cycles mid-prescale -> step is delayed by exactly 2 cycles.
